// File: rtl/counter_run_ctrl.sv
// Run controller: sequences an external up-counter through `repeats` runs,
// each counting 0..target, and reports busy/done/err to the host.
module counter_run_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] target,
  input  logic [REP_W-1:0] repeats,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_en,
  output logic             cnt_clr,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [REP_W-1:0] run_idx
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [REP_W-1:0]   repeats_q, repeats_d;
  logic [REP_W-1:0]   run_idx_q, run_idx_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      target_q  <= '0;
      repeats_q <= '0;
      run_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      repeats_q <= repeats_d;
      run_idx_q <= run_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    repeats_d = repeats_q;
    run_idx_d = run_idx_q;
    err_d     = 1'b0;
    cnt_en    = 1'b0;
    cnt_clr   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if ((target != '0) && (repeats != '0)) begin
            target_d  = target;
            repeats_d = repeats;
            run_idx_d = '0;
            state_d   = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        busy = 1'b1;
        // Abort leaves the counter untouched, so the clear is suppressed too.
        if (abort) begin
          state_d = IDLE;
        end else begin
          cnt_clr = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        cnt_en = (count != target_q) && !pause && !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (count == target_q) begin
          if (run_idx_q == repeats_q - REP_W'(1)) begin
            state_d = DONE;
          end else begin
            run_idx_d = run_idx_q + REP_W'(1);
            state_d   = CLEAR;
          end
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = !abort;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err     = err_q;
  assign run_idx = run_idx_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with a behavioural up-counter in the loop.
module tb_counter_run_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, pause;
  logic [3:0] target, repeats, count;
  logic       cnt_en, cnt_clr, busy, done, err;
  logic [3:0] run_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  int busy_cyc = 0, done_cyc = 0, err_cyc = 0, clr_cyc = 0, over_cyc = 0;
  int b0, d0, e0, c0, o0;
  logic [3:0] exp_tgt = 4'd0;

  always #5 clk = ~clk;

  counter_run_ctrl #(.WIDTH(4), .REP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .target(target), .repeats(repeats), .count(count),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
    .err(err), .run_idx(run_idx)
  );

  // The counter being controlled: synchronous clear beats enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       count <= 4'd0;
    else if (cnt_clr) count <= 4'd0;
    else if (cnt_en)  count <= count + 4'd1;
  end

  always @(negedge clk) begin
    if (busy)            busy_cyc++;
    if (done)            done_cyc++;
    if (err)             err_cyc++;
    if (cnt_clr)         clr_cyc++;
    if (count > exp_tgt) over_cyc++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic snap();
    b0 = busy_cyc; d0 = done_cyc; e0 = err_cyc; c0 = clr_cyc; o0 = over_cyc;
  endtask

  initial begin
    reset = 1'b0; start = 1'b1; abort = 1'b0; pause = 1'b0;
    target = 4'd5; repeats = 4'd2;

    // Reset held with start asserted
    repeat (2) step();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_idx", run_idx, 0);
    start = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_clr", cnt_clr, 0);

    // Basic: target=5, repeats=2
    exp_tgt = 4'd5;
    snap();
    target = 4'd5; repeats = 4'd2; start = 1'b1;
    step();
    start = 1'b0; #1;
    chk("b_clr0", cnt_clr, 1);
    chk("b_en_clr0", cnt_en, 0);
    chk("b_idx0", run_idx, 0);
    for (int r = 0; r < 2; r++) begin
      step(); #1;
      for (int i = 0; i < 5; i++) begin
        chk("b_cnt", count, i);
        chk("b_en", cnt_en, 1);
        step(); #1;
      end
      chk("b_term_cnt", count, 5);
      chk("b_term_en", cnt_en, 0);
      chk("b_term_idx", run_idx, r);
      step(); #1;
      if (r == 0) begin
        chk("b_clr1", cnt_clr, 1);
        chk("b_idx1", run_idx, 1);
      end
    end
    chk("b_done", done, 1);
    chk("b_done_busy", busy, 1);
    chk("b_done_en", cnt_en, 0);
    step(); #1;
    chk("b_idle_busy", busy, 0);
    chk("b_idle_done", done, 0);
    chk("b_idx_hold", run_idx, 1);
    chk("b_final_cnt", count, 5);
    chk("b_busy_cycles", busy_cyc - b0, 15);
    chk("b_done_cycles", done_cyc - d0, 1);
    chk("b_clr_cycles", clr_cyc - c0, 2);
    chk("b_overshoot", over_cyc - o0, 0);

    // Pause: target=9, repeats=1, paused 4 cycles at count=3
    exp_tgt = 4'd9;
    snap();
    target = 4'd9; repeats = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (3) step();
    pause = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      chk("p_hold_cnt", count, 3);
      chk("p_hold_en", cnt_en, 0);
      chk("p_hold_busy", busy, 1);
      step(); #1;
    end
    pause = 1'b0; #1;
    chk("p_resume_cnt", count, 3);
    chk("p_resume_en", cnt_en, 1);
    repeat (6) step();
    #1;
    chk("p_term_cnt", count, 9);
    pause = 1'b1; #1;
    step(); #1;
    chk("p_done_despite_pause", done, 1);
    pause = 1'b0;
    step(); #1;
    chk("p_idle_busy", busy, 0);
    chk("p_busy_cycles", busy_cyc - b0, 16);
    chk("p_done_cycles", done_cyc - d0, 1);
    chk("p_overshoot", over_cyc - o0, 0);

    // Illegal starts
    snap();
    target = 4'd0; repeats = 4'd3; start = 1'b1; #1;
    chk("i0_err_before", err, 0);
    step();
    start = 1'b0; #1;
    chk("i0_err", err, 1);
    chk("i0_busy", busy, 0);
    step(); #1;
    chk("i0_err_clear", err, 0);
    target = 4'd4; repeats = 4'd0; start = 1'b1;
    step();
    start = 1'b0; #1;
    chk("i1_err", err, 1);
    chk("i1_busy", busy, 0);
    step(); #1;
    chk("i_err_cycles", err_cyc - e0, 2);
    chk("i_busy_cycles", busy_cyc - b0, 0);
    target = 4'd0; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0; #1;
    chk("i_abort_no_err", err, 0);
    chk("i_abort_no_busy", busy, 0);

    // Abort at count=7 of run_idx=1
    exp_tgt = 4'd15;
    snap();
    target = 4'd15; repeats = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    repeat (15) step();
    #1;
    chk("a_term0", count, 15);
    step();
    step();
    repeat (7) step();
    #1;
    chk("a_cnt7", count, 7);
    chk("a_idx1", run_idx, 1);
    chk("a_en_pre", cnt_en, 1);
    abort = 1'b1; #1;
    chk("a_en_drop", cnt_en, 0);
    chk("a_no_clr", cnt_clr, 0);
    step();
    abort = 1'b0; #1;
    chk("a_idle_busy", busy, 0);
    step(); #1;
    chk("a_cnt_held", count, 7);
    chk("a_done_cycles", done_cyc - d0, 0);

    // Start while busy is ignored
    exp_tgt = 4'd3;
    snap();
    target = 4'd3; repeats = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    target = 4'd2; repeats = 4'd1; start = 1'b1;
    step();
    start = 1'b0; #1;
    chk("s_cnt2", count, 2);
    chk("s_en_past2", cnt_en, 1);
    step(); #1;
    chk("s_term0", count, 3);
    step();
    step();
    repeat (3) step();
    #1;
    chk("s_term1_idx", run_idx, 1);
    step(); #1;
    chk("s_done", done, 1);
    step(); #1;
    chk("s_busy_cycles", busy_cyc - b0, 11);
    chk("s_err_cycles", err_cyc - e0, 0);
    chk("s_done_cycles", done_cyc - d0, 1);

    // Asynchronous reset mid-run
    target = 4'd6; repeats = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #1;
    chk("r_busy_pre", busy, 1);
    reset = 1'b0; #1;
    chk("r_busy", busy, 0);
    chk("r_en", cnt_en, 0);
    chk("r_idx", run_idx, 0);
    step();
    reset = 1'b1;
    step(); #1;
    chk("r_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
